// File: rtl/road_pkg.sv
// road_pkg -- constants and types shared by the road/scroll game modules.
//   * FSM state encodings for the scroll controller
//   * default speed / frame-count parameters
//   * action classification enum used by the speed governor
//   * saturating 16-bit increment helper
package road_pkg;

  // Scroll controller FSM states (plain constants for legacy tools).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CRASH = 2'd2;

  // Default tuning: speed 8 means one scroll update per frame.
  localparam int DEF_MAX_SPEED    = 8;
  localparam int DEF_ACCEL_FRAMES = 8;
  localparam int DEF_DECEL_FRAMES = 16;
  localparam int DEF_CRASH_FRAMES = 120;

  localparam int SPEED_W = 4;
  localparam int PHASE_W = 3;
  localparam int DIST_W  = 16;

  // Player action seen on a frame_tick while running.
  typedef enum logic [1:0] {
    ACT_COAST = 2'd0,
    ACT_ACCEL = 2'd1,
    ACT_BRAKE = 2'd2
  } action_e;

  function automatic logic [DIST_W-1:0] sat_inc16(input logic [DIST_W-1:0] v);
    return (v == {DIST_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/scroll_phase_acc.sv
// scroll_phase_acc -- fractional scroll phase accumulator.
// Each enabled frame adds the current speed to a 3-bit phase; a carry out of
// the 3-bit range produces a one-cycle update pulse on the following cycle.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   acc_en          evaluate the accumulator this cycle (frame tick, not crashing)
//   acc_clr         force phase to 0 (crash entry); wins over acc_en
//   speed           speed value before this tick's speed update
//   update_signal   registered one-cycle scroll-advance pulse
module scroll_phase_acc
  import road_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               acc_en,
  input  logic               acc_clr,
  input  logic [SPEED_W-1:0] speed,
  output logic               update_signal
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               upd_q, upd_d;
  logic [SPEED_W-1:0] sum;

  // phase <= 7 and speed <= 8, so the sum always fits in 4 bits; bit 3 is the
  // ">= 8" flag and the low bits are already "sum - 8" when it is set.
  assign sum = {1'b0, phase_q} + speed;

  always_comb begin
    phase_d = phase_q;
    upd_d   = 1'b0;
    if (acc_clr) begin
      phase_d = '0;
    end else if (acc_en) begin
      phase_d = sum[PHASE_W-1:0];
      upd_d   = sum[PHASE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      upd_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      upd_q   <= upd_d;
    end
  end

  assign update_signal = upd_q;

endmodule

// File: rtl/scroll_controller.sv
// scroll_controller -- background scroll speed governor.
// Tracks IDLE/RUN/CRASH, ramps speed from the player's throttle/brake once per
// frame, and drives a phase accumulator that emits scroll-advance pulses.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   frame_tick      one-cycle pulse per video frame
//   accel, brake    player controls, sampled only on frame_tick
//   alive           0 = collision; forces CRASH on the next edge
//   update_signal   one-cycle scroll-advance pulse, cycle after a frame_tick
//   speed           current speed 0..MAX_SPEED
//   crash_active    high while in CRASH
//   distance        saturating count of update_signal pulses
module scroll_controller
  import road_pkg::*;
#(
  parameter int MAX_SPEED    = DEF_MAX_SPEED,
  parameter int ACCEL_FRAMES = DEF_ACCEL_FRAMES,
  parameter int DECEL_FRAMES = DEF_DECEL_FRAMES,
  parameter int CRASH_FRAMES = DEF_CRASH_FRAMES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               accel,
  input  logic               brake,
  input  logic               alive,
  output logic               update_signal,
  output logic [SPEED_W-1:0] speed,
  output logic               crash_active,
  output logic [DIST_W-1:0]  distance
);

  localparam int FRAME_MAX = (ACCEL_FRAMES > DECEL_FRAMES) ? ACCEL_FRAMES : DECEL_FRAMES;
  localparam int FW        = $clog2(FRAME_MAX + 1);
  localparam int CW        = $clog2(CRASH_FRAMES + 1);

  logic [1:0]         state_q, state_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [FW-1:0]      frame_q, frame_d, frame_eff;
  action_e            act_q, act_d, act_now;
  logic [CW-1:0]      crash_q, crash_d;
  logic [DIST_W-1:0]  distance_q, distance_d;
  logic               acc_en, acc_clr;

  assign act_now   = brake ? ACT_BRAKE : (accel ? ACT_ACCEL : ACT_COAST);
  // A change of action class restarts the frame count from zero on this tick.
  assign frame_eff = (act_now == act_q) ? frame_q : '0;

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    frame_d = frame_q;
    act_d   = act_q;
    crash_d = crash_q;
    acc_en  = 1'b0;
    acc_clr = 1'b0;
    if (state_q != ST_CRASH && !alive) begin
      // Collision beats everything, including a coincident frame_tick.
      state_d = ST_CRASH;
      speed_d = '0;
      frame_d = '0;
      crash_d = '0;
      acc_clr = 1'b1;
    end else if (frame_tick) begin
      case (state_q)
        ST_IDLE: begin
          acc_en = 1'b1;
          if (accel && !brake) begin
            state_d = ST_RUN;
            speed_d = SPEED_W'(1);
            frame_d = '0;
            act_d   = ACT_ACCEL;
          end
        end
        ST_RUN: begin
          acc_en = 1'b1;
          act_d  = act_now;
          case (act_now)
            ACT_BRAKE: begin
              frame_d = '0;
              if (speed_q != '0) speed_d = speed_q - 1'b1;
            end
            ACT_ACCEL: begin
              if (frame_eff == FW'(ACCEL_FRAMES - 1)) begin
                frame_d = '0;
                if (speed_q < SPEED_W'(MAX_SPEED)) speed_d = speed_q + 1'b1;
              end else begin
                frame_d = frame_eff + 1'b1;
              end
            end
            default: begin
              if (frame_eff == FW'(DECEL_FRAMES - 1)) begin
                frame_d = '0;
                if (speed_q != '0) speed_d = speed_q - 1'b1;
              end else begin
                frame_d = frame_eff + 1'b1;
              end
            end
          endcase
          if (speed_d == '0) state_d = ST_IDLE;
        end
        ST_CRASH: begin
          // Count up to CRASH_FRAMES, then leave on the first tick with alive=1.
          if (crash_q < CW'(CRASH_FRAMES)) begin
            crash_d = crash_q + 1'b1;
          end else if (alive) begin
            state_d = ST_IDLE;
            crash_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign distance_d = update_signal ? sat_inc16(distance_q) : distance_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      speed_q    <= '0;
      frame_q    <= '0;
      act_q      <= ACT_COAST;
      crash_q    <= '0;
      distance_q <= '0;
    end else begin
      state_q    <= state_d;
      speed_q    <= speed_d;
      frame_q    <= frame_d;
      act_q      <= act_d;
      crash_q    <= crash_d;
      distance_q <= distance_d;
    end
  end

  scroll_phase_acc u_phase (
    .clk           (clk),
    .reset         (reset),
    .acc_en        (acc_en),
    .acc_clr       (acc_clr),
    .speed         (speed_q),
    .update_signal (update_signal)
  );

  assign speed        = speed_q;
  assign crash_active = (state_q == ST_CRASH);
  assign distance     = distance_q;

endmodule

// File: tb/tb_scroll_controller.sv
// tb_scroll_controller -- directed self-checking bench for scroll_controller.
module tb_scroll_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        accel = 1'b0;
  logic        brake = 1'b0;
  logic        alive = 1'b1;
  logic        update_signal;
  logic [3:0]  speed;
  logic        crash_active;
  logic [15:0] distance;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;
  int wide_err = 0;
  int max_spd  = 0;
  int p_snap   = 0;
  logic        last_upd;
  logic        crash_next;
  logic [15:0] d_snap;

  always #5 clk = ~clk;

  scroll_controller dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .accel         (accel),
    .brake         (brake),
    .alive         (alive),
    .update_signal (update_signal),
    .speed         (speed),
    .crash_active  (crash_active),
    .distance      (distance)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s = %0d", tag, got);
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame: tick cycle, then the pulse cycle (sampled), then a gap cycle
  // that must show update_signal low again.
  task automatic tick(input logic a);
    @(negedge clk);
    frame_tick = 1'b1;
    alive      = a;
    @(negedge clk);
    frame_tick = 1'b0;
    alive      = 1'b1;
    last_upd   = update_signal;
    crash_next = crash_active;
    if (update_signal) pulses++;
    if (int'(speed) > max_spd) max_spd = int'(speed);
    @(negedge clk);
    if (update_signal) wide_err++;
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_speed", speed, 0);
    check("rst_crash", crash_active, 0);
    check("rst_upd", update_signal, 0);
    check("rst_dist", distance, 0);

    // Acceleration ramp: 8 ticks per speed step after the launch tick.
    accel = 1'b1;
    for (int t = 1; t <= 64; t++) begin
      tick(1'b1);
      if (t == 1)  check("ramp_t1", speed, 1);
      if (t == 9)  check("ramp_t9", speed, 2);
      if (t == 17) begin
        check("ramp_t17", speed, 3);
        check("phase_t17", dut.u_phase.phase_q, 0);
        p_snap = pulses;
      end
      if (t == 25) begin
        check("spd3_pulses", pulses - p_snap, 3);
        check("spd3_phase", dut.u_phase.phase_q, 0);
        check("ramp_t25", speed, 4);
      end
      if (t == 56) check("ramp_t56", speed, 7);
      if (t == 57) check("ramp_t57", speed, 8);
    end
    check("ramp_t64", speed, 8);
    check("ramp_max", max_spd, 8);
    check("ramp_dist", distance, 35);

    // Ten ticks at full speed: one pulse per tick, each one cycle wide.
    p_snap = pulses;
    for (int t = 0; t < 10; t++) tick(1'b1);
    check("full_pulses", pulses - p_snap, 10);
    check("full_width", wide_err, 0);
    check("full_dist", distance, 45);
    check("full_speed", speed, 8);

    // Brake down to 4, then brake+accel (brake wins), then coast.
    accel = 1'b0;
    brake = 1'b1;
    tick(1'b1);
    check("brake_7", speed, 7);
    repeat (3) tick(1'b1);
    check("brake_4", speed, 4);
    accel = 1'b1;
    tick(1'b1);
    check("both_3", speed, 3);
    tick(1'b1);
    check("both_2", speed, 2);
    accel = 1'b0;
    brake = 1'b0;
    repeat (15) tick(1'b1);
    check("coast_15", speed, 2);
    tick(1'b1);
    check("coast_16", speed, 1);

    // Back up to speed 5 for the crash test.
    accel = 1'b1;
    repeat (31) tick(1'b1);
    check("reacc_31", speed, 4);
    tick(1'b1);
    check("reacc_32", speed, 5);

    // Collision coinciding with a frame tick.
    d_snap = distance;
    tick(1'b0);
    check("crash_nopulse", last_upd, 0);
    check("crash_next", crash_next, 1);
    check("crash_speed", speed, 0);
    repeat (120) tick(1'b1);
    check("crash_120", crash_active, 1);
    tick(1'b0);
    check("crash_hold_dead", crash_active, 1);
    check("crash_dist_kept", distance, d_snap);
    tick(1'b1);
    check("crash_exit", crash_active, 0);
    check("crash_exit_spd", speed, 0);

    // Inputs between ticks do nothing.
    repeat (5) @(negedge clk);
    check("between_ticks", speed, 0);
    tick(1'b1);
    check("relaunch", speed, 1);

    // Reset mid-RUN, coinciding with a frame tick.
    @(negedge clk);
    reset      = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    check("mid_rst_speed", speed, 0);
    check("mid_rst_dist", distance, 0);
    check("mid_rst_upd", update_signal, 0);
    check("mid_rst_crash", crash_active, 0);
    reset      = 1'b0;
    frame_tick = 1'b0;

    // Distance saturation: tick every cycle at full speed until near the top.
    @(negedge clk);
    frame_tick = 1'b1;
    begin
      int i;
      for (i = 0; i < 70000 && distance != 16'hFFFE; i++) @(negedge clk);
      check("sat_reached", i < 70000, 1);
    end
    repeat (3) @(negedge clk);
    check("sat_pulsing", update_signal, 1);
    check("sat_ffff", distance, 16'hFFFF);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("sat_hold", distance, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
